// File: rtl/serial_and_using_mux_if.sv
// Operand/result handshake bundle for the bit-serial AND engine.
// master = producer/consumer side, slave = the engine itself.
interface serial_and_using_mux_if #(
  parameter int WIDTH = 8
);
  logic             arg_vld;
  logic             arg_rdy;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_vld;
  logic             res_rdy;
  logic [WIDTH-1:0] res;
  logic             busy;

  modport master (
    output arg_vld, a, b, res_rdy,
    input  arg_rdy, res_vld, res, busy
  );

  modport slave (
    input  arg_vld, a, b, res_rdy,
    output arg_rdy, res_vld, res, busy
  );
endinterface

// File: rtl/serial_and_using_mux.sv
// Bit-serial AND engine: one 2:1 mux wired as an AND gate, fed LSB first.
// Optional macro SERIAL_AND_EARLY_EXIT_EN stops shifting once the rest of A is zero.
module mux (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module serial_and_using_mux #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_and_using_mux_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, a_sh_next;
  logic [WIDTH-1:0] b_sh_reg, b_sh_next;
  logic [WIDTH-1:0] res_r_reg, res_r_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic             and_bit;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] res_wr;

  // The only gate on the data path: y = a ? b : 0.
  mux u_mux (
    .d0  (1'b0),
    .d1  (b_sh_reg[0]),
    .sel (a_sh_reg[0]),
    .y   (and_bit)
  );

  assign accept   = bus.arg_vld && (state_reg == IDLE);
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  // Per-bit write steering: only the bit addressed by cnt takes the gate output.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_res_wr
      assign res_wr[gi] = (cnt_reg == CW'(gi)) ? and_bit : res_r_reg[gi];
    end
  endgenerate

`ifdef SERIAL_AND_EARLY_EXIT_EN
  logic rest_zero;
  logic a_zero;
  assign rest_zero = ((a_sh_reg >> 1) == '0);
  assign a_zero    = (bus.a == '0);
`endif

  always_comb begin
    state_next = state_reg;
    a_sh_next  = a_sh_reg;
    b_sh_next  = b_sh_reg;
    res_r_next = res_r_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          a_sh_next  = bus.a;
          b_sh_next  = bus.b;
          res_r_next = '0;
          cnt_next   = '0;
`ifdef SERIAL_AND_EARLY_EXIT_EN
          state_next = a_zero ? DONE : SHIFT;
`else
          state_next = SHIFT;
`endif
        end
      end
      SHIFT: begin
        res_r_next = res_wr;
        a_sh_next  = a_sh_reg >> 1;
        b_sh_next  = b_sh_reg >> 1;
        cnt_next   = cnt_reg + 1'b1;
`ifdef SERIAL_AND_EARLY_EXIT_EN
        if (last_bit || rest_zero) begin
          state_next = DONE;
        end
`else
        if (last_bit) begin
          state_next = DONE;
        end
`endif
      end
      DONE: begin
        if (bus.res_rdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      res_r_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      a_sh_reg  <= a_sh_next;
      b_sh_reg  <= b_sh_next;
      res_r_reg <= res_r_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign bus.arg_rdy = (state_reg == IDLE);
  assign bus.busy    = (state_reg == SHIFT);
  assign bus.res_vld = (state_reg == DONE);
  assign bus.res     = res_r_reg;
endmodule

// File: tb/tb_serial_and_using_mux.sv
// Directed and randomized checks for serial_and_using_mux at WIDTH = 8.
// Expected latencies follow SERIAL_AND_EARLY_EXIT_EN when it is defined for the build.
module tb_serial_and_using_mux;
  localparam int WIDTH = 8;
`ifdef SERIAL_AND_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  serial_and_using_mux_if #(.WIDTH(WIDTH)) bus ();

  serial_and_using_mux #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands until the engine takes them; returns just after the accept edge.
  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    int n = 0;
    bus.arg_vld = 1'b1;
    bus.a = av;
    bus.b = bv;
    while (!bus.arg_rdy && n < 100) begin
      step();
      n++;
    end
    chk("accept_timeout", (n >= 100) ? 32'd1 : 32'd0, 32'd0);
    step();
    bus.arg_vld = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!bus.res_vld && lat < 100) begin
      step();
      lat++;
    end
    chk("res_timeout", (lat >= 100) ? 32'd1 : 32'd0, 32'd0);
  endtask

  logic [WIDTH-1:0] av_t [200];
  logic [WIDTH-1:0] bv_t [200];
  logic [WIDTH-1:0] exp_q [$];

  initial begin
    int lat;
    int n;
    bit seen;
    bit took;
    int idx_in;
    int idx_out;
    int cyc;
    logic [WIDTH-1:0] e;

    bus.arg_vld = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.res_rdy = 1'b0;

    // reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_arg_rdy", bus.arg_rdy, 1);
    chk("rst_res_vld", bus.res_vld, 0);
    chk("rst_res", bus.res, 0);
    chk("rst_busy", bus.busy, 0);

    // basic F0 & AA, result handshake immediate
    bus.res_rdy = 1'b1;
    send(8'hF0, 8'hAA);
    n = 0;
    while (bus.busy && n < 40) begin
      step();
      n++;
    end
    chk("basic_busy_cycles", n, WIDTH);
    chk("basic_res_vld", bus.res_vld, 1);
    chk("basic_res", bus.res, 8'hA0);
    $display("txn basic a=f0 b=aa res=%h busy=%0d", bus.res, n);
    step();
    chk("basic_vld_drop", bus.res_vld, 0);
    chk("basic_arg_rdy", bus.arg_rdy, 1);

    // backpressure
    bus.res_rdy = 1'b0;
    send(8'hFF, 8'h5C);
    wait_res(lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_vld", bus.res_vld, 1);
      chk("bp_res", bus.res, 8'h5C);
      chk("bp_arg_rdy", bus.arg_rdy, 0);
      step();
    end
    $display("txn backpressure a=ff b=5c res=%h", bus.res);
    bus.res_rdy = 1'b1;
    step();
    chk("bp_release_arg_rdy", bus.arg_rdy, 1);
    chk("bp_release_res_vld", bus.res_vld, 0);

    // operands offered while busy must be ignored
    send(8'h0F, 8'hFF);
    step();
    step();
    bus.arg_vld = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    wait_res(lat);
    chk("busy_ign_res", bus.res, 8'h0F);
    $display("txn busy_ignore a=0f b=ff res=%h", bus.res);
    n = 0;
    while (!bus.arg_rdy && n < 10) begin
      step();
      n++;
    end
    chk("busy_ign_idle", bus.arg_rdy, 1);
    step();
    bus.arg_vld = 1'b0;
    wait_res(lat);
    chk("busy_ign_second", bus.res, 8'hFF);
    $display("txn busy_second a=ff b=ff res=%h", bus.res);
    step();

    // reset during SHIFT discards the operation
    send(8'hFF, 8'hFF);
    step();
    step();
    step();
    chk("midrst_busy_before", bus.busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_arg_rdy", bus.arg_rdy, 1);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_res_vld", bus.res_vld, 0);
    chk("midrst_res", bus.res, 0);
    seen = 1'b0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      if (bus.res_vld) seen = 1'b1;
      step();
    end
    chk("midrst_no_result", seen, 0);
    $display("txn midrst a=ff b=ff discarded");

    // latency cases that depend on early exit
    send(8'h03, 8'hFF);
    wait_res(lat);
    chk("lat_03", lat, EE ? 2 : WIDTH);
    chk("res_03", bus.res, 8'h03);
    $display("txn lat a=03 b=ff res=%h lat=%0d", bus.res, lat);
    step();
    send(8'h00, 8'hFF);
    wait_res(lat);
    chk("lat_00", lat, EE ? 0 : WIDTH);
    chk("res_00", bus.res, 8'h00);
    $display("txn lat a=00 b=ff res=%h lat=%0d", bus.res, lat);
    step();
    send(8'h80, 8'h80);
    wait_res(lat);
    chk("lat_80", lat, WIDTH);
    chk("res_80", bus.res, 8'h80);
    $display("txn lat a=80 b=80 res=%h lat=%0d", bus.res, lat);
    step();

    // streaming with random gaps on both sides
    av_t[0] = 8'h00; bv_t[0] = 8'hFF;
    av_t[1] = 8'hFF; bv_t[1] = 8'hFF;
    av_t[2] = 8'h80; bv_t[2] = 8'hFF;
    av_t[3] = 8'h01; bv_t[3] = 8'h01;
    for (int i = 4; i < 200; i++) begin
      av_t[i] = WIDTH'($urandom);
      bv_t[i] = WIDTH'($urandom);
    end
    idx_in = 0;
    idx_out = 0;
    cyc = 0;
    while (idx_out < 200 && cyc < 20000) begin
      if (!bus.arg_vld && idx_in < 200 && $urandom_range(0, 3) != 0) begin
        bus.arg_vld = 1'b1;
        bus.a = av_t[idx_in];
        bus.b = bv_t[idx_in];
      end
      bus.res_rdy = ($urandom_range(0, 2) != 0);
      took = 1'b0;
      if (bus.arg_vld && bus.arg_rdy) begin
        exp_q.push_back(av_t[idx_in] & bv_t[idx_in]);
        idx_in++;
        took = 1'b1;
      end
      if (bus.res_vld && bus.res_rdy) begin
        if (exp_q.size() == 0) begin
          chk("rand_extra_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_res", bus.res, e);
          $display("txn rand #%0d res=%h exp=%h", idx_out, bus.res, e);
        end
        idx_out++;
      end
      step();
      if (took) bus.arg_vld = 1'b0;
      cyc++;
    end
    chk("rand_count", idx_out, 200);
    chk("rand_leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
